wbu: RTL and testbench
======================

// Module: wbu
// PURPOSE
//  Write-back stage directly downstream of the execute unit. Takes one result
//  per valid/ready handshake into a single-entry stage register, then retires
//  it into the architectural GPR file on the following edge.
//  Provides two combinational GPR read ports to decode.
//  Pulses a commit strobe with the retiring PC for trace/difftest.
// PARAMETERS
//  XLEN     32  data width of results and GPRs
//  NR_REGS  32  implemented GPRs (16 for RV32E); index >= NR_REGS is unimplemented
//  AW       5   register address width
// PORTS
//  clk           in   1     single clock, rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  in_valid      in   1     execute stage offers a result
//  in_ready      out  1     wbu accepts this cycle
//  in_rd         in   AW    destination register
//  in_wen        in   1     result writes a GPR (0 = no GPR effect, still commits)
//  in_result     in   XLEN  execute result
//  in_pc         in   XLEN  PC of the instruction
//  wb_stall      in   1     freeze retirement (debug halt / external hold)
//  rs1_addr      in   AW    read port 1 address
//  rs1_data      out  XLEN  read port 1 data (combinational)
//  rs2_addr      in   AW    read port 2 address
//  rs2_data      out  XLEN  read port 2 data (combinational)
//  commit_valid  out  1     one-cycle pulse: an instruction retired
//  commit_pc     out  XLEN  PC of the retired instruction
// BEHAVIOUR
//  - Reset (rst_n=0, async): wb_v=0, all GPRs=0, commit_valid=0, commit_pc=0.
//    A pending entry is discarded. in_ready reads 1 once reset is released.
//  - States: EMPTY (wb_v=0), FULL (wb_v=1).
//  - retire = wb_v & ~wb_stall; in_ready = ~wb_v | ~wb_stall.
//  - Accept when in_valid & in_ready: latch rd/wen/result/pc; wb_v<=1.
//  - Retire at an edge: if wen & rd!=0 & rd<NR_REGS, gpr[rd]<=result.
//    commit_valid<=1 and commit_pc<=pc on that edge, else commit_valid<=0.
//  - Simultaneous retire + accept: both happen at the same edge. wb_v stays 1.
//    Sustained rate is 1 instr/cycle.
//  - Retire with no accept: wb_v<=0. EMPTY with no accept: holds.
//  - Latency: accepted at edge N -> GPR updated and commit_valid high after N+1.
//  - FULL & wb_stall: in_ready=0. Entry and GPRs hold. commit_valid=0.
//  - x0 reads 0 always. Writes to x0 are dropped but still commit.
//  - Read address >= NR_REGS returns 0. Write to it is dropped but still commits.
//  - Read of a register being written at the same edge returns the old value
//    (unless WBU_BYPASS_EN is defined).
//  - in_* is ignored when in_valid=0. in_valid may drop without a handshake.
// CONFIGURATION
//  WBU_BYPASS_EN defined: rsN_data returns the staged result when wb_v & wen,
//  rd==rsN_addr, rd!=0, rd<NR_REGS. wb_stall does not block this forward.
//  Not defined: reads see GPR contents only. Decode must interlock on a
//  pending rd.
// TESTING
//  1. Reset, then accept rd=5 result=0x0000_1234 pc=0x8000_0000
//     -> next edge gpr[5]=0x1234, commit_valid=1 for one cycle,
//        commit_pc=0x8000_0000.
//  2. Back-to-back: rd=1,2,3 on 3 consecutive cycles, in_valid held
//     -> in_ready stays 1; commit_valid high 3 cycles; x1..x3 correct.
//  3. Write rd=0 result=0xFFFF_FFFF -> rs1_addr=0 reads 0; commit_valid=1.
//  4. FULL + wb_stall=1 for 4 cycles -> in_ready=0, commit_valid=0,
//     GPR unchanged; drop stall -> retires on the next edge.
//  5. Pending rd=7=0xDEAD_BEEF, rs1_addr=7 before retire
//     -> old value without WBU_BYPASS_EN; 0xDEAD_BEEF with it.
//  6. Entry FULL, assert rst_n=0 mid-cycle
//     -> wb_v, commit_valid clear immediately; write never lands; GPRs read 0.

Source files
------------

// File: rtl/wbu.sv
// wbu: write-back stage. A single-entry stage register takes one execute result
// per valid/ready handshake and retires it into the GPR file on the next edge,
// pulsing commit_valid/commit_pc. Two combinational GPR read ports serve decode.
// Optional feature macro: WBU_BYPASS_EN (forward the staged result to the read
// ports when it targets the addressed register).
module wbu #(
   parameter int XLEN    = 32,
   parameter int NR_REGS = 32,
   parameter int AW      = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rd,
   input  logic            in_wen,
   input  logic [XLEN-1:0] in_result,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_stall,
   input  logic [AW-1:0]   rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs2_data,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic            wen;
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] pc;
   } wb_entry_t;

   state_t          state_q, state_d;
   wb_entry_t       ent;
   logic [XLEN-1:0] gpr [NR_REGS];
   logic            wb_v, retire, accept;

   assign wb_v     = (state_q == FULL);
   assign retire   = wb_v & ~wb_stall;
   assign in_ready = ~wb_v | ~wb_stall;
   assign accept   = in_valid & in_ready;

   // State register; reset discards any pending entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Next state: an accept always leaves the stage full (covers retire+accept)
   always_comb begin
      state_d = state_q;
      if (accept)      state_d = FULL;
      else if (retire) state_d = EMPTY;
   end

   // Stage register captures the handshaked result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ent <= '0;
      else if (accept) ent <= '{rd: in_rd, wen: in_wen, result: in_result, pc: in_pc};
   end

   // GPR file; x0 and unimplemented indices never match a write, so they drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NR_REGS; i++) gpr[i] <= '0;
      end else if (retire && ent.wen) begin
         for (int i = 1; i < NR_REGS; i++)
            if (ent.rd == AW'(i)) gpr[i] <= ent.result;
      end
   end

   // Commit strobe is a one-cycle pulse per retired instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_valid <= 1'b0;
         commit_pc    <= '0;
      end else begin
         commit_valid <= retire;
         if (retire) commit_pc <= ent.pc;
      end
   end

   // Read ports: x0 and unimplemented addresses read as zero
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      for (int i = 1; i < NR_REGS; i++) begin
         if (rs1_addr == AW'(i)) rs1_data = gpr[i];
         if (rs2_addr == AW'(i)) rs2_data = gpr[i];
      end
`ifdef WBU_BYPASS_EN
      // Forward the staged result even while stalled; rd must be a real GPR
      for (int i = 1; i < NR_REGS; i++) begin
         if (wb_v && ent.wen && ent.rd == AW'(i)) begin
            if (rs1_addr == ent.rd) rs1_data = ent.result;
            if (rs2_addr == ent.rd) rs2_data = ent.result;
         end
      end
`endif
   end

endmodule

// File: tb/tb_wbu.sv
// tb_wbu: directed stimulus against wbu (RV32E build, NR_REGS=16, so the
// unimplemented-register rule is reachable with a 5-bit address). A spec-level
// model tracks the pending instruction and architectural registers; a compare
// process checks outputs on every falling edge, and directed literal checks
// pin the model.
module tb_wbu;
   localparam int XLEN = 32, NR = 16, AW = 5;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            in_valid = 1'b0, in_ready, in_wen = 1'b0, wb_stall = 1'b0;
   logic [AW-1:0]   in_rd = '0, rs1_addr = '0, rs2_addr = '0;
   logic [XLEN-1:0] in_result = '0, in_pc = '0, rs1_data, rs2_data, commit_pc;
   logic            commit_valid;

   int total = 0, bad = 0;

   wbu #(.XLEN(XLEN), .NR_REGS(NR), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_wen(in_wen), .in_result(in_result), .in_pc(in_pc),
      .wb_stall(wb_stall), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
      .rs2_addr(rs2_addr), .rs2_data(rs2_data), .commit_valid(commit_valid),
      .commit_pc(commit_pc));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- model: architectural state + one pending instruction
   logic [31:0] m_reg [32];
   bit          m_pend;
   logic [4:0]  m_rd;
   bit          m_wen;
   logic [31:0] m_res, m_pc, m_cpc;
   bit          m_cv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         foreach (m_reg[i]) m_reg[i] = 0;
         m_pend = 0; m_cv = 0; m_cpc = 0;
      end else begin
         bit done, take;
         done = m_pend && !wb_stall;
         take = in_valid && (!m_pend || !wb_stall);
         m_cv = done;
         if (done) begin
            m_cpc = m_pc;
            if (m_wen && m_rd != 0 && int'(m_rd) < NR) m_reg[m_rd] = m_res;
         end
         if (take) begin
            m_pend = 1; m_rd = in_rd; m_wen = in_wen; m_res = in_result; m_pc = in_pc;
         end else if (done) m_pend = 0;
      end
   end

   function automatic logic [31:0] m_read(input logic [4:0] a);
      if (a == 0 || int'(a) >= NR) return 0;
`ifdef WBU_BYPASS_EN
      if (m_pend && m_wen && m_rd == a) return m_res;
`endif
      return m_reg[a];
   endfunction

   // Compare process: every falling edge out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         chk("m_ready", {31'd0, in_ready}, {31'd0, (!m_pend || !wb_stall)});
         chk("m_cvalid", {31'd0, commit_valid}, {31'd0, m_cv});
         if (m_cv) chk("m_cpc", commit_pc, m_cpc);
         chk("m_rs1", rs1_data, m_read(rs1_addr));
         chk("m_rs2", rs2_data, m_read(rs2_addr));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic offer(input logic [4:0] rd, input logic wen, input logic [31:0] res, input logic [31:0] pc);
      in_valid = 1; in_rd = rd; in_wen = wen; in_result = res; in_pc = pc;
   endtask

   task automatic rd1(input logic [4:0] a, input string name, input logic [31:0] exp);
      rs1_addr = a; #1; chk(name, rs1_data, exp);
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_cvalid", {31'd0, commit_valid}, 32'd0);
      chk("rst_cpc", commit_pc, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // 1: single result, one-edge latency
      offer(5'd5, 1, 32'h0000_1234, 32'h8000_0000); tick();
      in_valid = 0;
      chk("t1_cv_early", {31'd0, commit_valid}, 32'd0);
      tick();
      chk("t1_cv", {31'd0, commit_valid}, 32'd1);
      chk("t1_cpc", commit_pc, 32'h8000_0000);
      rd1(5'd5, "t1_x5", 32'h0000_1234);
      tick();
      chk("t1_cv_pulse", {31'd0, commit_valid}, 32'd0);

      // 2: back-to-back at one per cycle
      offer(5'd1, 1, 32'h11, 32'h8000_0004);
      chk("t2_rdy1", {31'd0, in_ready}, 32'd1); tick();
      offer(5'd2, 1, 32'h22, 32'h8000_0008);
      chk("t2_rdy2", {31'd0, in_ready}, 32'd1); tick();
      chk("t2_cpc1", commit_pc, 32'h8000_0004);
      offer(5'd3, 1, 32'h33, 32'h8000_000C);
      chk("t2_rdy3", {31'd0, in_ready}, 32'd1); tick();
      chk("t2_cpc2", commit_pc, 32'h8000_0008);
      in_valid = 0; tick();
      chk("t2_cv3", {31'd0, commit_valid}, 32'd1);
      chk("t2_cpc3", commit_pc, 32'h8000_000C);
      rd1(5'd1, "t2_x1", 32'h11);
      rd1(5'd2, "t2_x2", 32'h22);
      rs2_addr = 5'd3; #1 chk("t2_x3", rs2_data, 32'h33);

      // 3: x0 write dropped but committed; wen=0 likewise
      offer(5'd0, 1, 32'hFFFF_FFFF, 32'h8000_0010); tick();
      offer(5'd6, 0, 32'h66, 32'h8000_0014); tick();
      chk("t3_cv", {31'd0, commit_valid}, 32'd1);
      in_valid = 0; tick();
      chk("t3_cpc_nowen", commit_pc, 32'h8000_0014);
      rd1(5'd0, "t3_x0", 32'h0);
      rd1(5'd6, "t3_x6", 32'h0);

      // unimplemented register boundary: x15 real, x16/x20 dropped
      offer(5'd15, 1, 32'h1515, 32'h8000_0018); tick();
      offer(5'd16, 1, 32'h1616, 32'h8000_001C); tick();
      offer(5'd20, 1, 32'h2020, 32'h8000_0020); tick();
      in_valid = 0; tick();
      chk("t3_cv_unimpl", {31'd0, commit_valid}, 32'd1);
      chk("t3_cpc_unimpl", commit_pc, 32'h8000_0020);
      rd1(5'd15, "t3_x15", 32'h1515);
      rd1(5'd16, "t3_x16", 32'h0);
      rd1(5'd20, "t3_x20", 32'h0);

      // 4: stall while full
      offer(5'd9, 1, 32'h99, 32'h100); wb_stall = 1; tick();
      in_valid = 0;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) offer(5'd10, 1, 32'hAA, 32'h104);
         if (k == 2) in_valid = 0;
         chk("t4_ready", {31'd0, in_ready}, 32'd0);
         chk("t4_cv", {31'd0, commit_valid}, 32'd0);
         rd1(5'd9, "t4_x9_hold", 32'h0);
         tick();
      end
      wb_stall = 0; tick();
      chk("t4_cv_rel", {31'd0, commit_valid}, 32'd1);
      chk("t4_cpc_rel", commit_pc, 32'h100);
      rd1(5'd9, "t4_x9", 32'h99);
      rd1(5'd10, "t4_x10", 32'h0);
      tick();

      // 5: read of a pending destination
      offer(5'd7, 1, 32'h7777, 32'h200); tick();
      in_valid = 0; tick();
      offer(5'd7, 1, 32'hDEAD_BEEF, 32'h204); tick();
      in_valid = 0; wb_stall = 1;
`ifdef WBU_BYPASS_EN
      rd1(5'd7, "t5_pending", 32'hDEAD_BEEF);
`else
      rd1(5'd7, "t5_pending", 32'h7777);
`endif
      tick();
      wb_stall = 0; tick();
      rd1(5'd7, "t5_after", 32'hDEAD_BEEF);

      // 6: async reset while full
      rs2_addr = 5'd5;
      offer(5'd12, 1, 32'h00C0_FFEE, 32'h300); tick();
      in_valid = 0;
      #2 rst_n = 0;
      #1;
      chk("t6_cv", {31'd0, commit_valid}, 32'd0);
      chk("t6_ready", {31'd0, in_ready}, 32'd1);
      chk("t6_x5", rs2_data, 32'h0);
      @(posedge clk); #1 rst_n = 1;
      tick(); tick();
      chk("t6_cv_after", {31'd0, commit_valid}, 32'd0);
      rd1(5'd12, "t6_x12", 32'h0);
      rd1(5'd7, "t6_x7", 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule
